// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-requester round-robin arbiter onto one shared native-bus
//            slave, with a per-transaction wait timeout and a sticky error.
// Ports    : clk, rst (async, active-low)
//            m0_* / m1_*  requester request (valid/address/wdata/wstrb) and
//                         response (rdata/ready)
//            s_*          shared slave request and response
//            err          sticky timeout flag, err_clr one-cycle clear pulse
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready,
    output logic                err,
    input  logic                err_clr
);

    localparam logic [0:0]        c_st_idle  = 1'b0;
    localparam logic [0:0]        c_st_busy  = 1'b1;
    localparam logic [15:0]       c_cnt_last = 16'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] c_dead     = {(DATA_W/32){32'hDEADBEEF}};

    logic [0:0]  r_state;
    logic        r_grant;   // 0 = m0, 1 = m1
    logic        r_last;    // requester served most recently
    logic [15:0] r_cnt;
    logic        r_err;

    logic              w_busy;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_resp_data;

    assign w_busy      = (r_state == c_st_busy);
    // A slave response in the final wait cycle wins over the timeout.
    assign w_timeout   = w_busy && !s_ready && (r_cnt == c_cnt_last);
    assign w_done      = w_busy && (s_ready || w_timeout);
    assign w_resp_data = s_ready ? s_rdata : c_dead;

    // Slave request is a pure mux of the locked grant; zero while idle.
    assign s_valid   = w_busy && (r_grant ? m1_valid : m0_valid);
    assign s_address = w_busy ? (r_grant ? m1_address : m0_address) : '0;
    assign s_wdata   = w_busy ? (r_grant ? m1_wdata   : m0_wdata)   : '0;
    assign s_wstrb   = w_busy ? (r_grant ? m1_wstrb   : m0_wstrb)   : '0;

    assign m0_ready  = w_done && !r_grant;
    assign m1_ready  = w_done &&  r_grant;
    assign m0_rdata  = m0_ready ? w_resp_data : '0;
    assign m1_rdata  = m1_ready ? w_resp_data : '0;

    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (m0_valid || m1_valid) begin
                        // On a tie the requester not served last wins.
                        r_grant <= (m0_valid && m1_valid) ? ~r_last : m1_valid;
                        r_cnt   <= 16'd0;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (w_done) begin
                        r_last  <= r_grant;
                        r_cnt   <= 16'd0;
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // Setting on timeout takes precedence over a coincident clear.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter: cycle vector table for
//            arbitration order and zero-wait transfers, directed sequences
//            for stalls, timeout, error flag handling and reset abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int c_n_vec = 16;

    logic        clk;
    logic        rst;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_address, m1_address, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        s_valid;
    logic [31:0] s_address, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_ready;
    logic        err, err_clr;

    int checks;
    int failures;

    bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_valid   (m0_valid),
        .m0_address (m0_address),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_rdata   (m0_rdata),
        .m0_ready   (m0_ready),
        .m1_valid   (m1_valid),
        .m1_address (m1_address),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_rdata   (m1_rdata),
        .m1_ready   (m1_ready),
        .s_valid    (s_valid),
        .s_address  (s_address),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_rdata    (s_rdata),
        .s_ready    (s_ready),
        .err        (err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0v;
        logic        m1v;
        logic [31:0] m0a;
        logic [31:0] m1a;
        logic        sr;
        logic [31:0] sd;
        logic        e_sv;
        logic [31:0] e_sa;
        logic [3:0]  e_ss;
        logic        e_r0;
        logic [31:0] e_d0;
        logic        e_r1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vt [c_n_vec];

    function automatic vec_t mk(input logic m0v, input logic m1v,
                                input logic [31:0] m0a, input logic [31:0] m1a,
                                input logic sr, input logic [31:0] sd,
                                input logic e_sv, input logic [31:0] e_sa,
                                input logic [3:0] e_ss, input logic e_r0,
                                input logic [31:0] e_d0, input logic e_r1,
                                input logic [31:0] e_d1);
        vec_t v;
        v.m0v = m0v;   v.m1v = m1v;   v.m0a = m0a;   v.m1a = m1a;
        v.sr = sr;     v.sd = sd;     v.e_sv = e_sv; v.e_sa = e_sa;
        v.e_ss = e_ss; v.e_r0 = e_r0; v.e_d0 = e_d0; v.e_r1 = e_r1;
        v.e_d1 = e_d1;
        return v;
    endfunction

    function automatic logic [134:0] obs();
        return {s_valid, s_address, s_wdata, s_wstrb,
                m0_ready, m0_rdata, m1_ready, m1_rdata};
    endfunction

    task automatic chk_vec(input string name, input logic [134:0] act,
                           input logic [134:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write data is always the inverted address so muxing errors show up.
    task automatic set_m0(input logic v, input logic [31:0] a, input logic [3:0] st);
        m0_valid = v; m0_address = a; m0_wdata = ~a; m0_wstrb = st;
    endtask

    task automatic set_m1(input logic v, input logic [31:0] a, input logic [3:0] st);
        m1_valid = v; m1_address = a; m1_wdata = ~a; m1_wstrb = st;
    endtask

    // Hold the current request through a stall of n BUSY cycles, firing the
    // slave response (when fire_ready) in the last one.
    task automatic stall_m0(input string name, input int n, input logic fire_ready,
                            input logic [31:0] exp_data);
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == n && fire_ready) begin
                s_ready = 1'b1;
                s_rdata = exp_data;
            end
            #1;
            if (k < n)
                chk(name, 64'({s_valid, m0_ready, m1_ready}), 64'(3'b100));
            else
                chk(name, 64'({s_valid, m0_ready, m0_rdata, m1_ready}),
                    64'({1'b1, 1'b1, exp_data, 1'b0}));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        err_clr  = 1'b0;
        s_ready  = 1'b1;
        s_rdata  = 32'h0;
        set_m0(1'b0, 32'h0, 4'h0);
        set_m1(1'b0, 32'h0, 4'h0);

        // --- reset state -----------------------------------------------------
        @(posedge clk); @(posedge clk); #2;
        chk_vec("reset_outputs", obs(), 135'd0);
        chk("reset_err", 64'(err), 64'(1'b0));
        @(negedge clk);
        rst = 1'b1;

        // --- vector table: round-robin back-to-back, then single m0 read ----
        vt[0]  = mk(1, 1, 32'h100, 32'h200, 1, 32'hD0, 0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);
        vt[1]  = mk(1, 1, 32'h100, 32'h200, 1, 32'hD1, 1, 32'h100, 4'h0, 1, 32'hD1, 0, 32'h0);
        vt[2]  = mk(1, 1, 32'h104, 32'h200, 1, 32'hD2, 0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);
        vt[3]  = mk(1, 1, 32'h104, 32'h200, 1, 32'hD3, 1, 32'h200, 4'hF, 0, 32'h0,  1, 32'hD3);
        vt[4]  = mk(1, 1, 32'h104, 32'h204, 1, 32'hD4, 0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);
        vt[5]  = mk(1, 1, 32'h104, 32'h204, 1, 32'hD5, 1, 32'h104, 4'h0, 1, 32'hD5, 0, 32'h0);
        vt[6]  = mk(1, 1, 32'h108, 32'h204, 1, 32'hD6, 0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);
        vt[7]  = mk(1, 1, 32'h108, 32'h204, 1, 32'hD7, 1, 32'h204, 4'hF, 0, 32'h0,  1, 32'hD7);
        vt[8]  = mk(1, 1, 32'h108, 32'h208, 1, 32'hD8, 0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);
        vt[9]  = mk(1, 1, 32'h108, 32'h208, 1, 32'hD9, 1, 32'h108, 4'h0, 1, 32'hD9, 0, 32'h0);
        vt[10] = mk(0, 1, 32'h0,   32'h208, 1, 32'hDA, 0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);
        vt[11] = mk(0, 1, 32'h0,   32'h208, 1, 32'hDB, 1, 32'h208, 4'hF, 0, 32'h0,  1, 32'hDB);
        vt[12] = mk(0, 0, 32'h0,   32'h0,   1, 32'hDC, 0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);
        vt[13] = mk(1, 0, 32'h12340000, 32'h0, 1, 32'h12345678, 0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0);
        vt[14] = mk(1, 0, 32'h12340000, 32'h0, 1, 32'h12345678, 1, 32'h12340000, 4'h0,
                    1, 32'h12345678, 0, 32'h0);
        vt[15] = mk(0, 0, 32'h0,   32'h0,   0, 32'h0,  0, 32'h0,   4'h0, 0, 32'h0,  0, 32'h0);

        for (int i = 0; i < c_n_vec; i++) begin
            step();
            set_m0(vt[i].m0v, vt[i].m0a, 4'h0);
            set_m1(vt[i].m1v, vt[i].m1a, 4'hF);
            s_ready = vt[i].sr;
            s_rdata = vt[i].sd;
            #1;
            chk_vec($sformatf("vec%0d", i), obs(),
                    {vt[i].e_sv, vt[i].e_sa, (vt[i].e_sv ? ~vt[i].e_sa : 32'h0),
                     vt[i].e_ss, vt[i].e_r0, vt[i].e_d0, vt[i].e_r1, vt[i].e_d1});
        end

        // --- m1 write, 5-cycle slave, m0 arrives mid-transaction -------------
        step();
        set_m1(1'b1, 32'h300, 4'hF);
        s_ready = 1'b0;
        s_rdata = 32'hBEEF0001;
        #1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 2) set_m0(1'b1, 32'h400, 4'h0);
            if (k == 5) s_ready = 1'b1;
            #1;
            chk("nopreempt_req", 64'({s_valid, s_address, s_wstrb}),
                64'({1'b1, 32'h300, 4'hF}));
            chk("nopreempt_rdy", 64'({m0_ready, m1_ready, m1_rdata}),
                64'({1'b0, (k == 5), (k == 5) ? 32'hBEEF0001 : 32'h0}));
        end
        step();
        set_m1(1'b0, 32'h0, 4'h0);
        #1;
        chk("gap_idle", 64'({s_valid, m0_ready, m1_ready}), 64'(3'b000));
        step();
        #1;
        chk("m0_after_m1", 64'({s_valid, s_address, m0_ready, m0_rdata}),
            64'({1'b1, 32'h400, 1'b1, 32'hBEEF0001}));

        // --- timeout with a slave that never answers ------------------------
        step();
        set_m0(1'b1, 32'h500, 4'h0);
        s_ready = 1'b0;
        #1;
        chk("to_idle", 64'({s_valid, m0_ready}), 64'(2'b00));
        stall_m0("timeout", 16, 1'b0, 32'hDEADBEEF);
        chk("err_before_edge", 64'(err), 64'(1'b0));
        step();
        set_m0(1'b0, 32'h0, 4'h0);
        s_ready = 1'b1;
        s_rdata = 32'h11111111;
        #1;
        chk("late_ready_ignored", 64'({s_valid, m0_ready, m1_ready, err}), 64'(4'b0001));
        step();
        s_ready = 1'b0;
        err_clr = 1'b1;
        #1;
        chk("err_sticky", 64'(err), 64'(1'b1));
        step();
        err_clr = 1'b0;
        #1;
        chk("err_cleared", 64'(err), 64'(1'b0));

        // --- slave answers exactly in the last allowed cycle ----------------
        step();
        set_m0(1'b1, 32'h600, 4'h0);
        #1;
        stall_m0("edge_ready", 16, 1'b1, 32'h600DDA7A);
        step();
        set_m0(1'b0, 32'h0, 4'h0);
        s_ready = 1'b0;
        #1;
        chk("edge_no_err", 64'(err), 64'(1'b0));

        // --- timeout coinciding with err_clr --------------------------------
        step();
        set_m0(1'b1, 32'h700, 4'h0);
        #1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 16) err_clr = 1'b1;
            #1;
        end
        chk("clr_to_fire", 64'({m0_ready, m0_rdata}), 64'({1'b1, 32'hDEADBEEF}));
        step();
        err_clr = 1'b0;
        set_m0(1'b0, 32'h0, 4'h0);
        #1;
        chk("err_set_wins", 64'(err), 64'(1'b1));

        // --- valid drop while busy, then reset abort ------------------------
        step();
        set_m0(1'b1, 32'h800, 4'h0);
        #1;
        step();
        #1;
        chk("abort_busy", 64'({s_valid, s_address}), 64'({1'b1, 32'h800}));
        step();
        set_m0(1'b0, 32'h800, 4'h0);
        set_m1(1'b1, 32'h900, 4'h0);
        #1;
        chk("drop_follow", 64'({s_valid, m0_ready, m1_ready}), 64'(3'b000));
        step();
        #1;
        chk("drop_hold1", 64'({s_valid, m0_ready, m1_ready}), 64'(3'b000));
        step();
        #1;
        chk("drop_hold2", 64'({s_valid, m0_ready, m1_ready}), 64'(3'b000));
        step();
        set_m0(1'b1, 32'h800, 4'h0);
        #1;
        chk("drop_regrant", 64'({s_valid, s_address}), 64'({1'b1, 32'h800}));
        #2;
        rst = 1'b0;
        #1;
        chk_vec("rst_async_out", obs(), 135'd0);
        chk("rst_async_err", 64'(err), 64'(1'b0));
        s_ready = 1'b1;
        s_rdata = 32'h22222222;
        step();
        #1;
        chk_vec("rst_held_out", obs(), 135'd0);
        @(negedge clk);
        rst = 1'b1;
        set_m0(1'b1, 32'hA00, 4'h0);
        set_m1(1'b1, 32'hB00, 4'h0);
        step();
        #1;
        chk("post_rst_tie", 64'({s_valid, s_address, m0_ready, m1_ready}),
            64'({1'b1, 32'hA00, 1'b1, 1'b0}));
        step();
        set_m0(1'b0, 32'h0, 4'h0);
        set_m1(1'b0, 32'h0, 4'h0);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
